// File: rtl/exu_mdu_pkg.sv
// Shared types and helpers for the multiply/divide execute unit.
package exu_mdu_pkg;

  localparam int MDU_OPT_WIDTH = 3;

  // Operation encoding follows the RV M-extension funct3 field.
  typedef enum logic [MDU_OPT_WIDTH-1:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_opt_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  function automatic logic opt_is_div(mdu_opt_e opt);
    return opt[2];
  endfunction

  function automatic logic opt_is_rem(mdu_opt_e opt);
    return opt[2] & opt[1];
  endfunction

  function automatic logic opt_src1_signed(mdu_opt_e opt);
    return (opt == MDU_MULH) || (opt == MDU_MULHSU) || (opt == MDU_DIV) || (opt == MDU_REM);
  endfunction

  function automatic logic opt_src2_signed(mdu_opt_e opt);
    return (opt == MDU_MULH) || (opt == MDU_DIV) || (opt == MDU_REM);
  endfunction

endpackage

// File: rtl/exu_mdu_if.sv
// Handshake and operand bundle between the EX stage and the multiply/divide unit.
interface exu_mdu_if #(
  parameter int XLEN = 32
) ();
  import exu_mdu_pkg::*;

  logic [XLEN-1:0]          i_src1;
  logic [XLEN-1:0]          i_src2;
  logic [MDU_OPT_WIDTH-1:0] i_opt;
  logic                     i_flush;
  logic                     i_pre_valid;
  logic                     o_pre_ready;
  logic                     o_post_valid;
  logic                     i_post_ready;
  logic [XLEN-1:0]          o_res;
  logic                     o_busy;

  // Pipeline side that issues operations and consumes results.
  modport master (
    output i_src1, i_src2, i_opt, i_flush, i_pre_valid, i_post_ready,
    input  o_pre_ready, o_post_valid, o_res, o_busy
  );

  // The unit itself.
  modport slave (
    input  i_src1, i_src2, i_opt, i_flush, i_pre_valid, i_post_ready,
    output o_pre_ready, o_post_valid, o_res, o_busy
  );

endinterface

// File: rtl/exu_mdu_divider.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step.
module mdu_divider #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quo,
  output logic [XLEN-1:0] o_rem
);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN:0]   trial;
  logic [XLEN:0]   diff;

  // The quotient register starts as the dividend and shifts its bits into the
  // partial remainder; the top bit of diff is the borrow of the trial subtract.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    trial = {rem_q, quo_q[XLEN-1]};
    diff  = trial - {1'b0, i_divisor};
    if (i_load) begin
      rem_d = '0;
      quo_d = i_dividend;
    end else if (i_step) begin
      if (!diff[XLEN]) begin
        rem_d = diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = trial[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  // Remainder/quotient state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign o_quo = quo_q;
  assign o_rem = rem_q;

endmodule

// File: rtl/exu_mdu.sv
// Multi-cycle RV M-extension execute unit: iterative multiply/divide with a
// one-cycle fast path for trivial cases and a pipeline flush.
module exu_mdu
  import exu_mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_FAST = 0
) (
  input logic      i_clk,
  input logic      i_rst_n,
  exu_mdu_if.slave mdu
);

  localparam int CNT_W = $clog2(XLEN);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mdu_opt_e          opt_q, opt_d;
  logic [XLEN-1:0]   mag1_q, mag1_d;
  logic [XLEN-1:0]   mag2_q, mag2_d;
  logic              neg_q, neg_d;
  logic              negr_q, negr_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   res_q, res_d;

  mdu_opt_e          opt_in;
  logic              sign1, sign2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              accept;
  logic              div_zero, div_ovf, mul_fast, fast;
  logic [XLEN-1:0]   fast_res;
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN:0]     acc_sum;
  logic              div_load, div_step;
  logic [XLEN-1:0]   div_quo, div_rem;

  // Signed result of a magnitude product, reduced to the requested half.
  function automatic logic [XLEN-1:0] mul_sel(mdu_opt_e opt, logic [2*XLEN-1:0] mag, logic neg);
    logic [2*XLEN-1:0] p;
    p = neg ? -mag : mag;
    return (opt == MDU_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // Operand decode at the accept point: magnitudes, result signs and fast-path results.
  always_comb begin
    opt_in    = mdu_opt_e'(mdu.i_opt);
    sign1     = opt_src1_signed(opt_in) & mdu.i_src1[XLEN-1];
    sign2     = opt_src2_signed(opt_in) & mdu.i_src2[XLEN-1];
    mag1      = sign1 ? -mdu.i_src1 : mdu.i_src1;
    mag2      = sign2 ? -mdu.i_src2 : mdu.i_src2;
    div_zero  = opt_is_div(opt_in) && (mdu.i_src2 == '0);
    div_ovf   = ((opt_in == MDU_DIV) || (opt_in == MDU_REM)) &&
                (mdu.i_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (mdu.i_src2 == '1);
    mul_fast  = (MUL_FAST != 0) && !opt_is_div(opt_in);
    fast      = div_zero || div_ovf || mul_fast;
    fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
    fast_res  = mul_sel(opt_in, fast_prod, sign1 ^ sign2);
    if (div_zero) begin
      fast_res = opt_is_rem(opt_in) ? mdu.i_src1 : '1;
    end else if (div_ovf) begin
      fast_res = opt_is_rem(opt_in) ? '0 : mdu.i_src1;
    end
  end

  assign accept  = (state_q == MDU_IDLE) && mdu.i_pre_valid && !mdu.i_flush;
  // Shift-add step: add the multiplicand into the upper half when the current
  // multiplier bit (held in the low half) is set, then shift right.
  assign acc_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mag1_q} : '0);

  // Next-state and datapath control for IDLE -> CALC -> FIX -> DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opt_d    = opt_q;
    mag1_d   = mag1_q;
    mag2_d   = mag2_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    prod_d   = prod_q;
    res_d    = res_q;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (accept) begin
          opt_d    = opt_in;
          mag1_d   = mag1;
          mag2_d   = mag2;
          neg_d    = sign1 ^ sign2;
          negr_d   = sign1;
          prod_d   = {{XLEN{1'b0}}, mag2};
          div_load = 1'b1;
          if (fast) begin
            res_d   = fast_res;
            state_d = MDU_DONE;
          end else begin
            cnt_d   = CNT_W'(XLEN-1);
            state_d = MDU_CALC;
          end
        end
      end
      MDU_CALC: begin
        if (opt_is_div(opt_q)) begin
          div_step = 1'b1;
        end else begin
          prod_d = {acc_sum, prod_q[XLEN-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = MDU_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MDU_FIX: begin
        if (opt_is_div(opt_q)) begin
          if (opt_is_rem(opt_q)) begin
            res_d = negr_q ? -div_rem : div_rem;
          end else begin
            res_d = neg_q ? -div_quo : div_quo;
          end
        end else begin
          res_d = mul_sel(opt_q, prod_q, neg_q);
        end
        state_d = MDU_DONE;
      end
      MDU_DONE: begin
        if (mdu.i_post_ready) begin
          state_d = MDU_IDLE;
        end
      end
      default: state_d = MDU_IDLE;
    endcase
    if (mdu.i_flush) begin
      state_d = MDU_IDLE;
    end
  end

  // State, counter, latched operands and result register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      opt_q   <= MDU_MUL;
      mag1_q  <= '0;
      mag2_q  <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      prod_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opt_q   <= opt_d;
      mag1_q  <= mag1_d;
      mag2_q  <= mag2_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
    end
  end

  mdu_divider #(.XLEN(XLEN)) u_divider (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (div_load),
    .i_step     (div_step),
    .i_dividend (mag1),
    .i_divisor  (mag2_q),
    .o_quo      (div_quo),
    .o_rem      (div_rem)
  );

  assign mdu.o_pre_ready  = (state_q == MDU_IDLE) && !mdu.i_flush;
  assign mdu.o_post_valid = (state_q == MDU_DONE);
  assign mdu.o_busy       = (state_q != MDU_IDLE);
  assign mdu.o_res        = res_q;

endmodule

// File: tb/tb_exu_mdu.sv
// Scoreboard bench for exu_mdu: three instances (32-bit iterative, 32-bit fast
// multiply, 64-bit iterative) share one stimulus port selected by 'sel'.
module tb_exu_mdu;
  import exu_mdu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] src1 = '0, src2 = '0;
  logic [2:0]  opt = 3'b000;
  logic        flush = 1'b0, pre_valid = 1'b0, post_ready = 1'b1;
  int          sel = 0;

  logic        m_pre_ready, m_post_valid, m_busy;
  logic [63:0] m_res;

  exu_mdu_if #(.XLEN(32)) bus_a ();
  exu_mdu_if #(.XLEN(32)) bus_b ();
  exu_mdu_if #(.XLEN(64)) bus_c ();

  exu_mdu #(.XLEN(32), .MUL_FAST(0)) u_a (.i_clk(clk), .i_rst_n(rst_n), .mdu(bus_a.slave));
  exu_mdu #(.XLEN(32), .MUL_FAST(1)) u_b (.i_clk(clk), .i_rst_n(rst_n), .mdu(bus_b.slave));
  exu_mdu #(.XLEN(64), .MUL_FAST(0)) u_c (.i_clk(clk), .i_rst_n(rst_n), .mdu(bus_c.slave));

  assign bus_a.i_src1 = src1[31:0];
  assign bus_a.i_src2 = src2[31:0];
  assign bus_a.i_opt = opt;
  assign bus_a.i_flush = flush;
  assign bus_a.i_pre_valid = pre_valid && (sel == 0);
  assign bus_a.i_post_ready = post_ready || (sel != 0);
  assign bus_b.i_src1 = src1[31:0];
  assign bus_b.i_src2 = src2[31:0];
  assign bus_b.i_opt = opt;
  assign bus_b.i_flush = flush;
  assign bus_b.i_pre_valid = pre_valid && (sel == 1);
  assign bus_b.i_post_ready = post_ready || (sel != 1);
  assign bus_c.i_src1 = src1;
  assign bus_c.i_src2 = src2;
  assign bus_c.i_opt = opt;
  assign bus_c.i_flush = flush;
  assign bus_c.i_pre_valid = pre_valid && (sel == 2);
  assign bus_c.i_post_ready = post_ready || (sel != 2);

  // Route the selected instance onto the observed outputs.
  always_comb begin
    m_pre_ready  = bus_a.o_pre_ready;
    m_post_valid = bus_a.o_post_valid;
    m_busy       = bus_a.o_busy;
    m_res        = {32'b0, bus_a.o_res};
    if (sel == 1) begin
      m_pre_ready  = bus_b.o_pre_ready;
      m_post_valid = bus_b.o_post_valid;
      m_busy       = bus_b.o_busy;
      m_res        = {32'b0, bus_b.o_res};
    end else if (sel == 2) begin
      m_pre_ready  = bus_c.o_pre_ready;
      m_post_valid = bus_c.o_post_valid;
      m_busy       = bus_c.o_busy;
      m_res        = bus_c.o_res;
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [63:0] q_res[$];
  int          q_lat[$];
  string       q_name[$];
  int          acc_c = 0;
  int          lat_m = 0;
  bit          pend = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_clear();
    q_res.delete();
    q_lat.delete();
    q_name.delete();
    pend = 1'b0;
  endtask

  // Monitor: measure accept-to-valid latency and compare each delivered result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pre_valid && m_pre_ready) begin
        acc_c = cyc;
        pend  = 1'b1;
      end
      if (m_post_valid) begin
        if (pend) begin
          lat_m = cyc - acc_c;
          pend  = 1'b0;
        end
        if (post_ready) begin
          if (q_res.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_result: got %h with no operation outstanding", m_res);
          end else begin
            check({q_name[0], "_res"}, m_res, q_res[0]);
            check({q_name[0], "_lat"}, 64'(lat_m), 64'(q_lat[0]));
            void'(q_res.pop_front());
            void'(q_lat.pop_front());
            void'(q_name.pop_front());
          end
        end
      end
    end
  end

  task automatic issue(input int s, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_res, input int lat, input string nm);
    bit ok;
    ok = 1'b0;
    sel = s;
    src1 = a;
    src2 = b;
    opt = op;
    pre_valid = 1'b1;
    q_res.push_back(exp_res);
    q_lat.push_back(lat);
    q_name.push_back(nm);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_pre_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    pre_valid = 1'b0;
    src1 = ~a;
    src2 = ~b;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_accept: o_pre_ready never rose within 50 cycles", nm);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (q_res.size() == 0) break;
      @(negedge clk);
    end
    if (q_res.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: %0d results still outstanding after 300 cycles", q_res.size());
      sb_clear();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int s, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp_res, input int lat, input string nm);
    issue(s, op, a, b, exp_res, lat, nm);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    // Reset values
    #12;
    check("rst_pre_ready", 64'(m_pre_ready), 64'd1);
    check("rst_post_valid", 64'(m_post_valid), 64'd0);
    check("rst_busy", 64'(m_busy), 64'd0);
    check("rst_res", m_res, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 32-bit iterative unit
    run(0, MDU_MUL,    64'd7,          64'hFFFFFFFD, 64'hFFFFFFEB, 34, "mul");
    run(0, MDU_MULH,   64'h80000000,   64'h80000000, 64'h40000000, 34, "mulh");
    run(0, MDU_MULHU,  64'hFFFFFFFF,   64'hFFFFFFFF, 64'hFFFFFFFE, 34, "mulhu");
    run(0, MDU_MULHSU, 64'hFFFFFFFF,   64'hFFFFFFFF, 64'hFFFFFFFF, 34, "mulhsu");
    run(0, MDU_DIV,    64'hFFFFFFF9,   64'd2,        64'hFFFFFFFD, 34, "div");
    run(0, MDU_REM,    64'hFFFFFFF9,   64'd2,        64'hFFFFFFFF, 34, "rem");
    run(0, MDU_DIVU,   64'd100,        64'd7,        64'd14,       34, "divu");
    run(0, MDU_REMU,   64'd100,        64'd7,        64'd2,        34, "remu");
    run(0, MDU_DIVU,   64'd5,          64'd0,        64'hFFFFFFFF, 1,  "divu_zero");
    run(0, MDU_REMU,   64'd5,          64'd0,        64'd5,        1,  "remu_zero");
    run(0, MDU_DIV,    64'hFFFFFFF9,   64'd0,        64'hFFFFFFFF, 1,  "div_zero");
    run(0, MDU_REM,    64'hFFFFFFF9,   64'd0,        64'hFFFFFFF9, 1,  "rem_zero");
    run(0, MDU_DIV,    64'h80000000,   64'hFFFFFFFF, 64'h80000000, 1,  "div_ovf");
    run(0, MDU_REM,    64'h80000000,   64'hFFFFFFFF, 64'd0,        1,  "rem_ovf");

    // Backpressure: result and handshake held while downstream stalls
    post_ready = 1'b0;
    issue(0, MDU_DIVU, 64'd100, 64'd7, 64'd14, 34, "bp_divu");
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (m_post_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(m_post_valid), 64'd1);
      check("bp_res", m_res, 64'd14);
      check("bp_pre_ready", 64'(m_pre_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    post_ready = 1'b1;
    wait_idle();
    check("bp_idle_pre_ready", 64'(m_pre_ready), 64'd1);

    // Flush in CALC cycle 10 kills the operation
    issue(0, MDU_MUL, 64'd7, 64'hFFFFFFFD, 64'hFFFFFFEB, 34, "flushed_mul");
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    sb_clear();
    check("flush_busy", 64'(m_busy), 64'd0);
    check("flush_post_valid", 64'(m_post_valid), 64'd0);
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_post_valid) saw = 1'b1;
    end
    check("flush_no_valid", 64'(saw), 64'd0);
    @(posedge clk);
    #1;
    run(0, MDU_MUL, 64'd7, 64'hFFFFFFFD, 64'hFFFFFFEB, 34, "post_flush_mul");

    // Flush together with pre_valid in IDLE: no accept
    sel = 0;
    src1 = 64'd100;
    src2 = 64'd7;
    opt = MDU_DIVU;
    flush = 1'b1;
    pre_valid = 1'b1;
    @(negedge clk);
    check("flush_idle_pre_ready", 64'(m_pre_ready), 64'd0);
    @(posedge clk);
    #1;
    pre_valid = 1'b0;
    flush = 1'b0;
    check("flush_idle_busy", 64'(m_busy), 64'd0);

    // Asynchronous reset mid-CALC
    issue(0, MDU_DIV, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 34, "reset_div");
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    sb_clear();
    check("mid_rst_busy", 64'(m_busy), 64'd0);
    check("mid_rst_post_valid", 64'(m_post_valid), 64'd0);
    check("mid_rst_pre_ready", 64'(m_pre_ready), 64'd1);
    check("mid_rst_res", m_res, 64'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(0, MDU_DIV, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 34, "post_rst_div");

    // 32-bit unit with single-cycle multiply
    run(1, MDU_MUL,  64'd7,        64'hFFFFFFFD, 64'hFFFFFFEB, 1,  "fast_mul");
    run(1, MDU_MULH, 64'h80000000, 64'h80000000, 64'h40000000, 1,  "fast_mulh");
    run(1, MDU_DIVU, 64'd100,      64'd7,        64'd14,       34, "fast_divu");

    // 64-bit unit with sign-extended operands
    run(2, MDU_DIV,   64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 66, "div64");
    run(2, MDU_REM,   64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 66, "rem64");
    run(2, MDU_MULH,  64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 64'd0, 66, "mulh64_sx");
    run(2, MDU_MULH,  64'h8000000000000000, 64'h8000000000000000, 64'h4000000000000000, 66, "mulh64_min");
    run(2, MDU_MULHU, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 66, "mulhu64");
    run(2, MDU_DIV,   64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1, "div64_ovf");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/exu_mdu.md
Name: exu_mdu

Overview:
Parametrised multi-cycle multiply/divide execute unit implementing the RV M-extension operations.
- Sits beside the combinational exu in the EX stage.
- Uses the same i_pre_valid/o_pre_ready and o_post_valid/i_post_ready handshake.
- Unlike the single-cycle exu, it holds state across cycles and can stall upstream.
- Provides a fast path for trivial cases and a flush for pipeline kill.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- MUL_FAST, 0, 1 = multiply done in one cycle (combinational product); 0 = iterative shift-add.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_src1  input  XLEN  operand rs1 (multiplicand/dividend)
- i_src2  input  XLEN  operand rs2 (multiplier/divisor)
- i_opt  input  `MDU_OPT_WIDTH (3)  operation, funct3 encoding
- i_flush  input  1  kill in-flight operation
- i_pre_valid  input  1  upstream has operation
- o_pre_ready  output  1  unit can accept
- o_post_valid  output  1  result available
- i_post_ready  input  1  downstream takes result
- o_res  output  XLEN  result
- o_busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: state=IDLE, o_post_valid=0, o_res=0, counter=0, o_busy=0. o_pre_ready=1 (combinational, state==IDLE && !i_flush).
- States:
  - IDLE: accept on i_pre_valid && o_pre_ready. Latch operands and opt.
    - Fast-path condition → DONE next cycle.
    - Otherwise → CALC with counter=XLEN-1.
  - CALC: one bit per cycle.
    - Multiply: shift-add on magnitudes into a 2*XLEN accumulator.
    - Divide: restoring subtract-shift on magnitudes via mdu_divider.
    - counter==0 → FIX, else counter-1.
  - FIX: one cycle. Apply sign correction, register o_res → DONE.
  - DONE: o_post_valid=1, o_res stable. On i_post_ready → IDLE.
- Latency (accept edge to o_post_valid high):
  - Normal path: XLEN+2 cycles (XLEN CALC + FIX + DONE entry).
  - Fast path: 1 cycle.
- Fast path cases:
  - MUL_FAST=1 with any multiply op.
  - Divisor == 0: DIV/DIVU → all ones; REM/REMU → dividend.
  - Signed overflow (DIV/REM, src1 == 1<<(XLEN-1), src2 == all ones): DIV → src1; REM → 0.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: src1 signed, src2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
- Result selection and sign rules:
  - MUL → low XLEN bits of product. MULH* → high XLEN bits.
  - Product sign = sign1 ^ sign2.
  - Quotient sign = sign1 ^ sign2. Remainder sign = sign of dividend.
  - All arithmetic is two's complement. Magnitude of most-negative value is taken as unsigned XLEN bits.
- Handshake:
  - o_pre_ready is low in CALC/FIX/DONE. No back-to-back accept in DONE.
  - Result is held while i_post_ready=0, for any number of cycles.
  - o_post_valid must not drop without i_post_ready or flush.
- Flush:
  - i_flush in any state → IDLE next edge, o_post_valid=0.
  - i_flush with i_pre_valid in IDLE → no accept.
  - o_res keeps its last value; it is don't-care while o_post_valid=0.
- Reset mid-operation: immediate return to reset values. No partial result is ever presented.
- Operands are latched at accept. Changes on i_src1/i_src2 during CALC have no effect.

Decomposition:
- defines.vh gains:
  - `MDU_OPT_WIDTH=3
  - `MDU_MUL=3'b000, `MDU_MULH=001, `MDU_MULHSU=010, `MDU_MULHU=011
  - `MDU_DIV=100, `MDU_DIVU=101, `MDU_REM=110, `MDU_REMU=111
  - state encodings `MDU_IDLE/CALC/FIX/DONE
- One sub-module, mdu_divider:
  - One restoring-division step per enable.
  - Parametrised XLEN; holds remainder/quotient registers.
  - Controlled by exu_mdu's counter.
- Multiply datapath stays in exu_mdu.

Test Plan:
- XLEN=32, MUL 7 × 0xFFFFFFFD → o_res=0xFFFFFFEB; o_post_valid exactly 34 cycles after accept (MUL_FAST=0), 1 cycle with MUL_FAST=1.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM 0xFFFFFFF9/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- Corner cases, each with 1-cycle latency:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Backpressure and flush:
  - Hold i_post_ready=0 for 5 cycles in DONE → o_res/o_post_valid stable, o_pre_ready=0.
  - Assert i_flush at CALC cycle 10 → IDLE next cycle, no o_post_valid; next op completes correctly.
- Reset mid-CALC: deassert i_rst_n asynchronously → outputs at reset values the same cycle; XLEN=64 rerun of the DIV/MULH vectors, sign-extended, gives 64-bit-correct results.
